// File: rtl/stopwatch_ctrl_if.sv
// Button/display bus between the stopwatch sequencer and its environment.
//   start_stop, lap_reset : debounced one-cycle button pulses (master -> slave)
//   count                 : elapsed ms (live accumulator or lap snapshot)
//   running, lap_active   : state indicators
//   saturated             : sticky, accumulator reached its maximum
//   ms_tick               : one-cycle pulse per counted millisecond
interface stopwatch_ctrl_if #(
  parameter int unsigned BITS = 26
) ();
  logic            start_stop;
  logic            lap_reset;
  logic [BITS-1:0] count;
  logic            running;
  logic            lap_active;
  logic            saturated;
  logic            ms_tick;

  modport master (
    output start_stop, lap_reset,
    input  count, running, lap_active, saturated, ms_tick
  );

  modport slave (
    input  start_stop, lap_reset,
    output count, running, lap_active, saturated, ms_tick
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Millisecond stopwatch sequencer: divides clk into a 1 ms tick, keeps the
// elapsed-ms accumulator and runs the start/stop/lap/clear state machine.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : stopwatch_ctrl_if.slave (button pulses in, count/status out)
module stopwatch_ctrl #(
  parameter int unsigned BITS    = 26,
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned MAX_MS  = 35999999
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned PW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_LAP     = 2'd2,
    S_PAUSED  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic [BITS-1:0] r_acc;
  logic [BITS-1:0] r_lap;
  logic            r_sat;
  logic            r_tick;

  logic w_run;
  logic w_wrap;
  logic w_sat_hit;
  logic w_ss;
  logic w_clear;
  logic w_capture;

  // Prescaler only advances while the watch is counting (RUNNING or LAP).
  assign w_run     = (r_state == S_RUNNING) || (r_state == S_LAP);
  assign w_wrap    = w_run && (r_presc == PW'(CLK_DIV - 1));
  // A tick arriving at the ceiling is swallowed and freezes the watch.
  assign w_sat_hit = w_wrap && (r_acc == BITS'(MAX_MS));
  // Once saturated, start_stop is dead until a clear.
  assign w_ss      = bus.start_stop && !((r_state == S_PAUSED) && r_sat);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start_stop has priority over lap_reset.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss) w_state_nxt = S_RUNNING;
      end
      S_RUNNING: begin
        if (w_ss) begin
          w_state_nxt = S_PAUSED;
        end else if (bus.lap_reset) begin
          w_state_nxt = S_LAP;
          w_capture   = 1'b1;
        end
      end
      S_LAP: begin
        if (w_ss) begin
          w_state_nxt = S_PAUSED;
        end else if (bus.lap_reset) begin
          w_state_nxt = S_RUNNING;
        end
      end
      S_PAUSED: begin
        if (w_ss) begin
          w_state_nxt = S_RUNNING;
        end else if (bus.lap_reset) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Saturation overrides any button action in the same cycle.
    if (w_sat_hit) begin
      w_state_nxt = S_PAUSED;
      w_capture   = 1'b0;
    end
  end

  // Datapath: prescaler, tick pipeline, accumulator, lap snapshot, sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_acc   <= '0;
      r_lap   <= '0;
      r_sat   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_wrap && !w_sat_hit;
      if (w_clear) begin
        r_presc <= '0;
        r_acc   <= '0;
        r_lap   <= '0;
        r_sat   <= 1'b0;
      end else begin
        // acc follows ms_tick by one edge; lap captures the pre-increment value.
        if (r_tick)    r_acc <= r_acc + BITS'(1);
        if (w_capture) r_lap <= r_acc;
        if (w_sat_hit) r_sat <= 1'b1;
        // PAUSED holds the sub-ms phase; IDLE keeps it at zero.
        if (w_wrap) begin
          r_presc <= '0;
        end else if (w_run) begin
          r_presc <= r_presc + PW'(1);
        end else if (r_state == S_IDLE) begin
          r_presc <= '0;
        end
      end
    end
  end

  // Outputs are pure register decodes.
  assign bus.count      = (r_state == S_LAP) ? r_lap : r_acc;
  assign bus.running    = w_run;
  assign bus.lap_active = (r_state == S_LAP);
  assign bus.saturated  = r_sat;
  assign bus.ms_tick    = r_tick;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam int unsigned BITS = 26;
  localparam int unsigned DIV  = 4;
  localparam int unsigned MAXV = 20;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_LAP   = 2;
  localparam int M_PAUSE = 3;

  logic clk;
  logic reset;

  stopwatch_ctrl_if #(.BITS(BITS)) bus ();

  stopwatch_ctrl #(
    .BITS   (BITS),
    .CLK_DIV(DIV),
    .MAX_MS (MAXV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: watch mode, elapsed ms, clk cycles into current ms.
  int m_mode  = M_IDLE;
  int m_ms    = 0;
  int m_lap   = 0;
  int m_phase = 0;
  bit m_sat   = 1'b0;
  bit m_tick  = 1'b0;

  typedef struct {
    bit ss;
    bit lr;
    bit rst;
    int cnt;
    bit run;
    bit lap;
    bit sat;
    bit tick;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit ss, input bit lr, input bit rst);
    bit run;
    bit wrap;
    bit hit;
    bit sse;
    int old_ms;
    if (rst) begin
      m_mode = M_IDLE; m_ms = 0; m_lap = 0; m_phase = 0; m_sat = 0; m_tick = 0;
      return;
    end
    run  = (m_mode == M_RUN) || (m_mode == M_LAP);
    wrap = run && (m_phase == int'(DIV) - 1);
    hit  = wrap && (m_ms == int'(MAXV));
    sse  = ss && !(m_mode == M_PAUSE && m_sat);
    if (m_mode == M_PAUSE && !sse && lr) begin
      m_mode = M_IDLE; m_ms = 0; m_lap = 0; m_phase = 0; m_sat = 0; m_tick = 0;
      return;
    end
    old_ms = m_ms;
    if (m_tick) m_ms = m_ms + 1;
    m_tick = wrap && !hit;
    if (run) m_phase = wrap ? 0 : m_phase + 1;
    else if (m_mode == M_IDLE) m_phase = 0;
    if (hit) begin
      m_sat  = 1;
      m_mode = M_PAUSE;
    end else begin
      case (m_mode)
        M_IDLE:  if (sse) m_mode = M_RUN;
        M_RUN:   if (sse) m_mode = M_PAUSE;
                 else if (lr) begin m_lap = old_ms; m_mode = M_LAP; end
        M_LAP:   if (sse) m_mode = M_PAUSE;
                 else if (lr) m_mode = M_RUN;
        default: if (sse) m_mode = M_RUN;
      endcase
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare at negedge.
  task automatic cycle(input bit ss, input bit lr, input bit rst);
    bus.start_stop = ss;
    bus.lap_reset  = lr;
    reset          = rst;
    @(posedge clk);
    model_edge(ss, lr, rst);
    @(negedge clk);
    chk("count",      32'(bus.count),     32'((m_mode == M_LAP) ? m_lap : m_ms));
    chk("running",    32'(bus.running),   32'((m_mode == M_RUN) || (m_mode == M_LAP)));
    chk("lap_active", 32'(bus.lap_active), 32'(m_mode == M_LAP));
    chk("saturated",  32'(bus.saturated), 32'(m_sat));
    chk("ms_tick",    32'(bus.ms_tick),   32'(m_tick));
  endtask

  task automatic run_until(input int tgt);
    int n;
    n = 0;
    while (int'(bus.count) != tgt && n < 200) begin
      cycle(0, 0, 0);
      n++;
    end
    chk("reach_count", 32'(bus.count), 32'(tgt));
  endtask

  task automatic setv(input int i, input bit ss, input bit lr, input bit rst,
                      input int cnt, input bit run, input bit lap, input bit sat, input bit tick);
    tbl[i].ss = ss; tbl[i].lr = lr; tbl[i].rst = rst; tbl[i].cnt = cnt;
    tbl[i].run = run; tbl[i].lap = lap; tbl[i].sat = sat; tbl[i].tick = tick;
  endtask

  initial begin
    int ticks;
    int n;
    bus.start_stop = 1'b0;
    bus.lap_reset  = 1'b0;
    reset          = 1'b1;

    //      ss lr rst cnt run lap sat tick
    setv( 0, 0, 0, 1,  0,  0,  0,  0,  0);
    setv( 1, 1, 0, 0,  0,  1,  0,  0,  0);
    setv( 2, 0, 0, 0,  0,  1,  0,  0,  0);
    setv( 3, 0, 0, 0,  0,  1,  0,  0,  0);
    setv( 4, 0, 0, 0,  0,  1,  0,  0,  0);
    setv( 5, 0, 0, 0,  0,  1,  0,  0,  1);
    setv( 6, 0, 0, 0,  1,  1,  0,  0,  0);
    setv( 7, 0, 1, 0,  1,  1,  1,  0,  0);
    setv( 8, 0, 0, 0,  1,  1,  1,  0,  0);
    setv( 9, 0, 0, 0,  1,  1,  1,  0,  1);
    setv(10, 0, 0, 0,  1,  1,  1,  0,  0);
    setv(11, 0, 1, 0,  2,  1,  0,  0,  0);
    setv(12, 1, 0, 0,  2,  0,  0,  0,  0);
    setv(13, 0, 0, 0,  2,  0,  0,  0,  0);
    setv(14, 1, 0, 0,  2,  1,  0,  0,  0);
    setv(15, 0, 0, 0,  2,  1,  0,  0,  1);
    setv(16, 0, 0, 0,  3,  1,  0,  0,  0);
    setv(17, 1, 1, 0,  3,  0,  0,  0,  0);
    setv(18, 0, 1, 0,  0,  0,  0,  0,  0);
    setv(19, 0, 1, 0,  0,  0,  0,  0,  0);

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].ss, tbl[i].lr, tbl[i].rst);
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_running", i), 32'(bus.running), 32'(tbl[i].run));
      chk($sformatf("vec%0d_lap", i), 32'(bus.lap_active), 32'(tbl[i].lap));
      chk($sformatf("vec%0d_sat", i), 32'(bus.saturated), 32'(tbl[i].sat));
      chk($sformatf("vec%0d_tick", i), 32'(bus.ms_tick), 32'(tbl[i].tick));
    end

    // 40 clk of running yields 10 ticks; reset mid-run wins over a button.
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 0);
      if (bus.ms_tick) ticks++;
    end
    chk("t1_ticks", 32'(ticks), 32'd10);
    cycle(0, 0, 0);
    chk("t1_count", 32'(bus.count), 32'd10);
    chk("t1_running", 32'(bus.running), 32'd1);
    cycle(1, 0, 1);
    chk("t1_rst_count", 32'(bus.count), 32'd0);
    chk("t1_rst_running", 32'(bus.running), 32'd0);

    // Pause preserves the sub-ms phase: 2 clk into the ms at pause, tick 2 clk after resume.
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    run_until(5);
    cycle(1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0);
    chk("t2_frozen", 32'(bus.count), 32'd5);
    cycle(1, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0);
      n++;
      if (bus.ms_tick) break;
    end
    chk("t2_tick_latency", 32'(n), 32'd2);

    // Lap snapshot holds 7 while acc advances; release shows 10.
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    run_until(7);
    cycle(0, 1, 0);
    chk("t3_lap_active", 32'(bus.lap_active), 32'd1);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0);
    chk("t3_lap_count", 32'(bus.count), 32'd7);
    cycle(0, 1, 0);
    chk("t3_release_count", 32'(bus.count), 32'd10);
    chk("t3_release_lap", 32'(bus.lap_active), 32'd0);

    // Simultaneous pulses in LAP: start_stop wins, then clear.
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    run_until(3);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(1, 1, 0);
    chk("t4_running", 32'(bus.running), 32'd0);
    chk("t4_lap", 32'(bus.lap_active), 32'd0);
    cycle(0, 1, 0);
    chk("t4_clear", 32'(bus.count), 32'd0);

    // Saturation at 20, start_stop ignored, clear releases.
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    for (int i = 0; i < 100; i++) cycle(0, 0, 0);
    chk("t5_count", 32'(bus.count), 32'd20);
    chk("t5_sat", 32'(bus.saturated), 32'd1);
    chk("t5_running", 32'(bus.running), 32'd0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("t5_ss_ignored", 32'(bus.running), 32'd0);
    cycle(0, 1, 0);
    chk("t5_clear_count", 32'(bus.count), 32'd0);
    chk("t5_clear_sat", 32'(bus.saturated), 32'd0);

    // lap_reset in IDLE does nothing.
    cycle(0, 1, 0);
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_running", 32'(bus.running), 32'd0);

    // Random buttons and occasional reset against the model.
    cycle(0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the millisecond stopwatch datapath.
- Divides the system clock into a 1 ms tick and maintains the elapsed-ms accumulator.
- Runs a start/stop/lap/clear state machine from two debounced button pulses.
- Drives the `count` bus consumed by count2watch, which converts it to hr:min:s:ms.

Parameters:
- BITS, 26: width of the `count` output and the accumulator; must match the BITS of count2watch.
- CLK_DIV, 50000: clk cycles per millisecond. Must be ≥ 2.
- MAX_MS, 35999999: saturation value, i.e. 9:59:59.999. Must be < 2^BITS.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_stop  input  1  one-cycle pulse, already debounced; start/pause/resume.
- lap_reset  input  1  one-cycle pulse, already debounced; lap capture/release, or clear when paused.
- count  output  BITS  elapsed ms shown to count2watch (live accumulator, or lap snapshot in LAP).
- running  output  1  high in RUNNING and LAP.
- lap_active  output  1  high in LAP.
- saturated  output  1  sticky; accumulator hit MAX_MS.
- ms_tick  output  1  one-cycle pulse per counted millisecond.

Behaviour:

Reset:
- reset=1 at a clk edge forces state=IDLE, acc=0, lap_reg=0, prescaler=0, saturated=0, ms_tick=0.
- Consequently count=0, running=0, lap_active=0.
- Reset overrides any simultaneous button pulse, including mid-run.

Prescaler:
- Width is clog2(CLK_DIV).
- Counts 0..CLK_DIV-1 only while running=1.
- On the cycle it equals CLK_DIV-1 it wraps to 0 and ms_tick is registered high for the next cycle.
- Holds its value in PAUSED, so a sub-ms fraction is preserved across pause/resume.
- Cleared to 0 in IDLE.

Accumulator:
- acc increments by 1 in the same cycle ms_tick is high. count therefore reflects a tick one cycle after ms_tick asserts, i.e. two clk edges after the prescaler wrap.
- If a tick arrives with acc==MAX_MS:
  - acc holds at MAX_MS (no wrap);
  - saturated is set;
  - state goes to PAUSED;
  - ms_tick is suppressed for that tick.
- In PAUSED with saturated=1, start_stop is ignored; only lap_reset (clear) is accepted.

FSM (evaluated per clk, with reset=0):
- IDLE:
  - start_stop -> RUNNING.
  - lap_reset is ignored.
- RUNNING:
  - start_stop -> PAUSED.
  - lap_reset -> LAP and lap_reg <= acc; the captured value is the pre-increment acc if a tick coincides.
- LAP (acc keeps counting; count shows lap_reg):
  - lap_reset -> RUNNING (display goes live).
  - start_stop -> PAUSED (display shows the frozen acc).
- PAUSED:
  - start_stop -> RUNNING (unless saturated).
  - lap_reset -> IDLE: acc, lap_reg and prescaler are cleared and saturated goes to 0, all at the next edge.
- Both pulses in the same cycle: start_stop wins and lap_reset is dropped.

Outputs:
- count = (state==LAP) ? lap_reg : acc, a mux of registers only with no combinational path from the inputs.
- running, lap_active and saturated are registered or state-decoded.
- Button effects appear on outputs one cycle after the pulse edge.

Test Plan (CLK_DIV=4, MAX_MS=20, BITS=26):
1. Reset, then start_stop pulse, run 40 clk -> running=1, 10 ms_tick pulses, count=10. Assert reset mid-run -> next edge count=0, running=0.
2. Run to count=5, start_stop; wait 20 clk; start_stop again -> count frozen at 5 during pause. First tick after resume comes after 4 minus the elapsed prescaler phase clk cycles, confirming the phase is preserved.
3. Run to count=7, lap_reset -> lap_active=1, count stays 7 while acc advances. After 12 clk, lap_reset -> count=10, lap_active=0.
4. Run to count=3, lap_reset; then start_stop and lap_reset in the same cycle -> PAUSED (start_stop wins), count shows live acc. A following lap_reset -> IDLE, count=0.
5. Run 100 clk -> count saturates at 20, saturated=1, running=0. start_stop ignored. lap_reset -> count=0, saturated=0.
6. In IDLE, pulse lap_reset -> no state change, count=0, running=0.
